// File: rtl/lib_intr.sv
// Shared types and helpers for the interrupt scheduler.
package lib_intr;

    localparam int unsigned N_SRC_MAX   = 8;
    localparam int unsigned CAUSE_W_MAX = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } INTR_STATE;

    // Fixed priority: lowest set index wins; returns 0 when nothing is set.
    function automatic logic [CAUSE_W_MAX-1:0] fn_prio_sel(input logic [N_SRC_MAX-1:0] pending);
        logic [CAUSE_W_MAX-1:0] sel;
        sel = '0;
        for (int i = N_SRC_MAX - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = CAUSE_W_MAX'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/intr_edge_latch.sv
// Per-source rising-edge detector with a sticky pending bit.
module intr_edge_latch (
    input  logic clk,
    input  logic rst_n,
    input  logic irq_i,
    input  logic clr_i,
    output logic pending_o
);

    logic irq_q;
    logic pend_q;
    logic pend_d;
    logic rise;

    // A new edge must never be lost, so set beats a coincident clear.
    always_comb begin
        rise   = irq_i & ~irq_q;
        pend_d = rise | (pend_q & ~clr_i);
    end

    // Previous irq level and pending bit; irq_q clears so a held source re-fires after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            irq_q  <= irq_i;
            pend_q <= pend_d;
        end
    end

    assign pending_o = pend_q;

endmodule

// File: rtl/intr_sched.sv
// Interrupt scheduler: latches source edges, picks one by fixed priority,
// requests an injected ICALL and tracks it until software acknowledges.
module intr_sched
    import lib_intr::*;
#(
    parameter int unsigned N_SRC   = 2,
    parameter int unsigned CAUSE_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   irq,
    input  logic               intr_en,
    input  logic               insn_bound,
    input  logic               icall_take,
    input  logic               ack,
    output logic               icall_req,
    output logic [CAUSE_W-1:0] cause,
    output logic [N_SRC-1:0]   pending,
    output logic               busy
);

    INTR_STATE              state_q;
    INTR_STATE              state_d;
    logic [CAUSE_W-1:0]     cause_q;
    logic [CAUSE_W-1:0]     cause_d;
    logic                   icall_req_q;
    logic                   icall_req_d;
    logic [N_SRC-1:0]       pend_vec;
    logic [N_SRC-1:0]       clr_vec;
    logic [N_SRC_MAX-1:0]   pend_ext;
    logic [CAUSE_W_MAX-1:0] sel;

    // One edge latch per source; only the in-service source is cleared, on ack.
    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign clr_vec[i] = (state_q == SERVICE) && ack && (cause_q == CAUSE_W'(i));

        intr_edge_latch u_latch (
            .clk       (clk),
            .rst_n     (rst_n),
            .irq_i     (irq[i]),
            .clr_i     (clr_vec[i]),
            .pending_o (pend_vec[i])
        );
    end

    // Widen pending to the helper's fixed width and pick the winner.
    always_comb begin
        pend_ext             = '0;
        pend_ext[N_SRC-1:0]  = pend_vec;
        sel                  = fn_prio_sel(pend_ext);
    end

    // Next-state, cause capture and request decode.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        icall_req_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((|pend_vec) && intr_en && insn_bound) begin
                    state_d = REQ;
                    cause_d = CAUSE_W'(sel);
                end
            end
            REQ: begin
                if (icall_take) begin
                    state_d = SERVICE;
                end else if (!intr_en) begin
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        icall_req_d = (state_d == REQ);
    end

    // State, cause and request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cause_q     <= '0;
            icall_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            icall_req_q <= icall_req_d;
        end
    end

    assign icall_req = icall_req_q;
    assign cause     = cause_q;
    assign pending   = pend_vec;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_intr_sched.sv
// Directed bench for intr_sched with hand-computed expectations.
module tb_intr_sched;

    logic       clk;
    logic       rst_n;
    logic [1:0] irq;
    logic       intr_en;
    logic       insn_bound;
    logic       icall_take;
    logic       ack;
    logic       icall_req;
    logic [2:0] cause;
    logic [1:0] pending;
    logic       busy;

    int n_vec;
    int n_err;

    intr_sched #(.N_SRC(2), .CAUSE_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .irq        (irq),
        .intr_en    (intr_en),
        .insn_bound (insn_bound),
        .icall_take (icall_take),
        .ack        (ack),
        .icall_req  (icall_req),
        .cause      (cause),
        .pending    (pending),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are then observed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic req, input logic [2:0] c,
                             input logic [1:0] p, input logic b);
        check({tag, ".icall_req"}, 32'(icall_req), 32'(req));
        check({tag, ".cause"},     32'(cause),     32'(c));
        check({tag, ".pending"},   32'(pending),   32'(p));
        check({tag, ".busy"},      32'(busy),      32'(b));
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        irq        = 2'b00;
        intr_en    = 1'b0;
        insn_bound = 1'b0;
        icall_take = 1'b0;
        ack        = 1'b0;
        #12;
        check_all("reset", 1'b0, 3'd0, 2'b00, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single request on source 1
        intr_en = 1'b1; insn_bound = 1'b1;
        irq = 2'b10;
        tick();
        check_all("single.pend", 1'b0, 3'd0, 2'b10, 1'b0);
        tick();
        check_all("single.req", 1'b1, 3'd1, 2'b10, 1'b1);
        tick();
        check_all("single.hold", 1'b1, 3'd1, 2'b10, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;
        check_all("single.svc", 1'b0, 3'd1, 2'b10, 1'b1);
        ack = 1'b1; tick(); ack = 1'b0;
        check_all("single.ack", 1'b0, 3'd1, 2'b00, 1'b0);
        tick();
        check_all("single.quiet", 1'b0, 3'd1, 2'b00, 1'b0);
        irq = 2'b00; tick();

        // Priority: both rise together, source 0 first
        irq = 2'b11;
        tick();
        check_all("prio.pend", 1'b0, 3'd1, 2'b11, 1'b0);
        tick();
        check_all("prio.req0", 1'b1, 3'd0, 2'b11, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        check_all("prio.ack0", 1'b0, 3'd0, 2'b10, 1'b0);
        tick();
        check_all("prio.req1", 1'b1, 3'd1, 2'b10, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        check_all("prio.ack1", 1'b0, 3'd1, 2'b00, 1'b0);
        irq = 2'b00; tick();

        // Gating and withdrawal
        intr_en = 1'b0;
        irq = 2'b01;
        tick();
        tick();
        tick();
        check_all("gate.off", 1'b0, 3'd1, 2'b01, 1'b0);
        intr_en = 1'b1; tick();
        check_all("gate.on", 1'b1, 3'd0, 2'b01, 1'b1);
        intr_en = 1'b0; tick();
        check_all("gate.withdraw", 1'b0, 3'd0, 2'b01, 1'b0);
        intr_en = 1'b1; tick();
        check_all("gate.reissue", 1'b1, 3'd0, 2'b01, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;

        // Set beats clear: irq[0] re-rises on the ack cycle
        irq = 2'b00; tick();
        irq = 2'b01; ack = 1'b1; tick(); ack = 1'b0;
        check_all("setclr.idle", 1'b0, 3'd0, 2'b01, 1'b0);
        tick();
        check_all("setclr.req", 1'b1, 3'd0, 2'b01, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;

        // Stray handshakes
        icall_take = 1'b1; tick(); icall_take = 1'b0;
        check_all("stray.take", 1'b0, 3'd0, 2'b01, 1'b1);
        ack = 1'b1; tick(); ack = 1'b0;
        check_all("stray.svcack", 1'b0, 3'd0, 2'b00, 1'b0);
        ack = 1'b1; tick(); ack = 1'b0;
        check_all("stray.idleack", 1'b0, 3'd0, 2'b00, 1'b0);

        // Mid-service reset with irq[1] held high
        irq = 2'b10;
        tick();
        tick();
        check_all("rst.req", 1'b1, 3'd1, 2'b10, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;
        check_all("rst.svc", 1'b0, 3'd1, 2'b10, 1'b1);
        rst_n = 1'b0;
        #1;
        check_all("rst.async", 1'b0, 3'd0, 2'b00, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        check_all("rst.pend", 1'b0, 3'd0, 2'b10, 1'b0);
        tick();
        check_all("rst.req1", 1'b1, 3'd1, 2'b10, 1'b1);
        icall_take = 1'b1; tick(); icall_take = 1'b0;
        ack = 1'b1; tick(); ack = 1'b0;
        check_all("rst.ack", 1'b0, 3'd1, 2'b00, 1'b0);
        tick();
        tick();
        check_all("rst.norepeat", 1'b0, 3'd1, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
